// File: rtl/vector_sweep_checker.sv
// Exhaustive sweep checker: drives every input vector to a combinational DUT,
// compares its single output against a truth table and reports pass/fail.
module vector_sweep_checker #(
    parameter int                      N_IN        = 3,
    parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = 8'h31,
    parameter int                      SETTLE      = 2,
    parameter int                      FAIL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop_on_fail,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic                  first_fail_valid,
    output logic [N_IN-1:0]       first_fail_vec
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    // One extra bit so the last-vector compare never aliases with vector 0.
    localparam logic [N_IN:0] VEC_LAST = (N_IN + 1)'((1 << N_IN) - 1);

    logic [1:0]    state;
    logic [N_IN:0] vec;
    logic [SW-1:0] settle_cnt;
    logic          stop_flag;
    logic          mismatch;

    // Written as if/else so an unknown dut_y falls through to a mismatch.
    always_comb begin
        mismatch = 1'b1;
        if (dut_y == TRUTH_TABLE[vec[N_IN-1:0]])
            mismatch = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            stop_flag        <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= APPLY;
                        vec              <= '0;
                        settle_cnt       <= '0;
                        stop_flag        <= stop_on_fail;
                        fail_count       <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= CHECK;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (fail_count != '1)
                            fail_count <= fail_count + 1'b1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec[N_IN-1:0];
                        end
                    end
                    if (vec == VEC_LAST || (mismatch && stop_flag)) begin
                        state <= DONE;
                    end else begin
                        state      <= APPLY;
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == APPLY) || (state == CHECK);
    assign done   = (state == DONE);
    assign pass   = done && (fail_count == '0);
    assign dut_in = busy ? vec[N_IN-1:0] : '0;
endmodule

// File: tb/tb_vector_sweep_checker.sv
// Randomized bench for vector_sweep_checker: a fault mask flips the golden
// function per vector and a reference model predicts every sweep result.
module tb_vector_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop_on_fail;
    logic [7:0] mask;

    logic [2:0] dut_in,  dut_in2;
    logic       dut_y,   dut_y2;
    logic       busy,    busy2;
    logic       done,    done2;
    logic       pass,    pass2;
    logic [7:0] fail_count;
    logic [1:0] fail_count2;
    logic       ffv,     ffv2;
    logic [2:0] ffvec,   ffvec2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Golden function straight from the boolean equation, a=v[2] b=v[1] c=v[0].
    function automatic logic golden(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    function automatic logic [7:0] golden_table();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = golden(3'(i));
        return t;
    endfunction

    always_comb dut_y  = golden(dut_in)  ^ mask[dut_in];
    always_comb dut_y2 = golden(dut_in2) ^ mask[dut_in2];

    vector_sweep_checker #(.N_IN(3), .TRUTH_TABLE(8'h31), .SETTLE(2), .FAIL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .dut_in(dut_in), .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_valid(ffv), .first_fail_vec(ffvec));

    vector_sweep_checker #(.N_IN(3), .TRUTH_TABLE(8'h31), .SETTLE(2), .FAIL_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .dut_in(dut_in2), .dut_y(dut_y2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fail_count2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    // Edges are numbered with the start-sampling edge as edge 1; each vector
    // occupies SETTLE+1 = 3 edges, so after edge k the vector is (k-1)/3.
    task automatic run_sweep(input logic [7:0] m, input logic stop, input int repulse,
                             output int done_edge);
        int k;
        mask = m;
        stop_on_fail = stop;
        start = 1'b1;
        @(posedge clk);
        k = 1;
        @(negedge clk);
        start = 1'b0;
        done_edge = -1;
        while (k < 200) begin
            if (done) begin
                done_edge = k;
                break;
            end
            checks++;
            if (busy !== 1'b1 || dut_in !== 3'((k - 1) / 3) || dut_in2 !== dut_in) begin
                errors++;
                $display("FAIL sweep_trace edge %0d: busy=%b dut_in=%0d dut_in2=%0d want busy=1 dut_in=%0d",
                         k, busy, dut_in, dut_in2, (k - 1) / 3);
            end
            start = (k == repulse);
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
        end
        if (done_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: done not seen within 200 edges");
        end
    endtask

    // Reference model: expected results from the fault mask and the stop mode.
    task automatic check_result(input string name, input logic [7:0] m, input logic stop,
                                input int done_edge);
        int nf, first, exp_edge, exp_fc, exp_fc2;
        nf = 0;
        first = -1;
        for (int i = 0; i < 8; i++) if (m[i]) begin
            nf++;
            if (first < 0) first = i;
        end
        exp_edge = (stop && nf > 0) ? 1 + (first + 1) * 3 : 25;
        exp_fc   = (stop && nf > 0) ? 1 : nf;
        exp_fc2  = (exp_fc > 3) ? 3 : exp_fc;
        checks++;
        if (done_edge != exp_edge) begin
            errors++;
            $display("FAIL %s done_edge: got %0d want %0d", name, done_edge, exp_edge);
        end
        checks++;
        if (fail_count !== 8'(exp_fc) || fail_count2 !== 2'(exp_fc2)) begin
            errors++;
            $display("FAIL %s fail_count: got %0d/%0d want %0d/%0d",
                     name, fail_count, fail_count2, exp_fc, exp_fc2);
        end
        checks++;
        if (pass !== (nf == 0) || pass2 !== (nf == 0) || done2 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pass: got pass=%b pass2=%b done2=%b busy=%b want pass=%b",
                     name, pass, pass2, done2, busy, nf == 0);
        end
        checks++;
        if (ffv !== (nf > 0) || (nf > 0 && ffvec !== 3'(first)) || ffv2 !== ffv || ffvec2 !== ffvec) begin
            errors++;
            $display("FAIL %s first_fail: got valid=%b vec=%0d want valid=%b vec=%0d",
                     name, ffv, ffvec, nf > 0, first);
        end
        checks++;
        if (dut_in !== 3'd0) begin
            errors++;
            $display("FAIL %s dut_in_done: got %0d want 0", name, dut_in);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop_on_fail = 1'b0;
        mask = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, fail_count, ffv, ffvec, dut_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b fc=%0d ffv=%b ffvec=%0d dut_in=%0d want all 0",
                     busy, done, pass, fail_count, ffv, ffvec, dut_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_golden();
        int de;
        run_sweep(8'h00, 1'b0, 0, de);
        check_result("golden", 8'h00, 1'b0, de);
    endtask

    task automatic test_stuck0();
        int de;
        logic [7:0] m;
        m = golden_table();
        run_sweep(m, 1'b0, 0, de);
        check_result("stuck0", m, 1'b0, de);
        run_sweep(m, 1'b1, 0, de);
        check_result("stuck0_stop", m, 1'b1, de);
    endtask

    task automatic test_mid_reset();
        int de, n;
        mask = 8'h00;
        stop_on_fail = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (dut_in !== 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL midreset_wait: dut_in never reached 5, got %0d", dut_in);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fail_count, ffv, ffvec, dut_in} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b fc=%0d dut_in=%0d want all 0",
                     busy, done, fail_count, dut_in);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(8'h00, 1'b0, 0, de);
        check_result("after_reset", 8'h00, 1'b0, de);
    endtask

    task automatic test_back_to_back();
        int de;
        run_sweep(8'h00, 1'b0, 7, de);
        check_result("repulse_busy", 8'h00, 1'b0, de);
        run_sweep(8'hFF, 1'b0, 0, de);
        check_result("inverted_sat", 8'hFF, 1'b0, de);
    endtask

    task automatic test_random();
        int de;
        logic [7:0] m;
        logic stop;
        for (int it = 0; it < 10; it++) begin
            m = 8'($urandom);
            if (it == 0) m = 8'h80;
            if (it == 1) m = 8'h40;
            stop = 1'($urandom_range(0, 1));
            run_sweep(m, stop, 0, de);
            check_result($sformatf("random%0d_m%02h_s%0d", it, m, stop), m, stop, de);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck0();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
